// File: rtl/tweak_pkg.sv
// Shared tweak ISA definitions: format codes, field widths, opcodes and writer states.
package tweak_pkg;

  typedef enum logic [1:0] {
    FMT_D24    = 2'b00,
    FMT_R4D20  = 2'b01,
    FMT_R8D16  = 2'b10,
    FMT_R12D12 = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int REGS_W = 12;
  localparam int DATA_W = 24;
  localparam int WORD_W = 32;

  localparam logic [1:0] LSU_NOP   = 2'b00;
  localparam logic [1:0] LSU_LOAD  = 2'b01;
  localparam logic [1:0] LSU_STORE = 2'b10;
  localparam logic [1:0] LSU_SWAP  = 2'b11;

  localparam logic [3:0] ALU_PASS = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_AND  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;

  function automatic int unsigned fmt_regs_width(fmt_e fmt);
    case (fmt)
      FMT_D24:   return 0;
      FMT_R4D20: return 4;
      FMT_R8D16: return 8;
      default:   return 12;
    endcase
  endfunction

  function automatic int unsigned fmt_data_width(fmt_e fmt);
    return 24 - fmt_regs_width(fmt);
  endfunction

endpackage

// File: rtl/tweak_encoder.sv
// Combinational packer: builds the 32-bit instruction word and flags fields too wide for the format.
module tweak_encoder
  import tweak_pkg::*;
(
  input  logic [1:0]        fmt,
  input  logic [1:0]        lsu,
  input  logic [3:0]        alu,
  input  logic [REGS_W-1:0] regs,
  input  logic [DATA_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              overflow
);

  fmt_e        fmt_sel;
  int unsigned regs_w;
  int unsigned data_w;
  logic [23:0] payload;
  logic        regs_over;
  logic        data_over;

  assign fmt_sel = fmt_e'(fmt);
  assign regs_w  = fmt_regs_width(fmt_sel);
  assign data_w  = fmt_data_width(fmt_sel);

  always_comb begin
    payload = data;
    case (fmt_sel)
      FMT_D24:    payload = data;
      FMT_R4D20:  payload = {regs[3:0], data[19:0]};
      FMT_R8D16:  payload = {regs[7:0], data[15:0]};
      FMT_R12D12: payload = {regs[11:0], data[11:0]};
      default:    payload = data;
    endcase
  end

  // The 24-bit-data format carries no register field, so in_regs is ignored there
  assign regs_over = (fmt_sel != FMT_D24) && ((regs >> regs_w) != '0);
  assign data_over = (data >> data_w) != '0;
  assign overflow  = regs_over | data_over;
  assign word      = {fmt, lsu, alu, payload};

endmodule

// File: rtl/tweak_prog_writer.sv
// Program loader: accepts encoded instructions over a valid/ready handshake and writes them
// one per two cycles into instruction memory starting at address 0.
module tweak_prog_writer
  import tweak_pkg::*;
#(
  parameter int NUMWORDS = 8,
  parameter int ADDRW    = 4
) (
  input  logic              CLK,
  input  logic              NRES,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [1:0]        in_lsu,
  input  logic [3:0]        in_alu,
  input  logic [11:0]       in_regs,
  input  logic [23:0]       in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDRW-1:0]  mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDRW:0]    word_count
);

  localparam logic [ADDRW:0] COUNT_MAX = (ADDRW+1)'(NUMWORDS);

  state_e           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [ADDRW:0]   count_q, count_d;
  logic [31:0]      word_q, word_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic             full_q, full_d;
  logic [ADDRW:0]   count_inc;
  logic [31:0]      enc_word;
  logic             enc_overflow;

  tweak_encoder u_encoder (
    .fmt      (in_fmt),
    .lsu      (in_lsu),
    .alu      (in_alu),
    .regs     (in_regs),
    .data     (in_data),
    .word     (enc_word),
    .overflow (enc_overflow)
  );

  assign count_inc = count_q + (ADDRW+1)'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = err_q;
    full_d  = full_q;
    // start restarts from any state and beats a same-cycle handshake; a WRITE in progress
    // still drives mem_we this cycle because mem_we is decoded from the current state
    if (start) begin
      state_d = ST_FILL;
      addr_d  = '0;
      count_d = '0;
      last_d  = 1'b0;
      err_d   = 1'b0;
      full_d  = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (in_valid) begin
            if (enc_overflow) begin
              err_d = 1'b1;
            end else begin
              word_d  = enc_word;
              last_d  = in_last;
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          count_d = count_inc;
          // Address stays put on the final word so it never points past the memory
          if (count_inc == COUNT_MAX) begin
            full_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + ADDRW'(1);
            state_d = last_q ? ST_DONE : ST_FILL;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
      full_q  <= full_d;
    end
  end

  assign in_ready   = (state_q == ST_FILL) && !start;
  assign mem_we     = (state_q == ST_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q;
  assign busy       = (state_q == ST_FILL) || (state_q == ST_WRITE);
  assign done       = (state_q == ST_DONE);
  assign full       = full_q;
  assign err        = err_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_tweak_prog_writer.sv
// Directed self-checking bench for tweak_prog_writer with hand-computed expected words.
module tb_tweak_prog_writer;

  logic        CLK = 1'b0;
  logic        NRES;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [1:0]  in_lsu;
  logic [3:0]  in_alu;
  logic [11:0] in_regs;
  logic [23:0] in_data;
  logic        in_last;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        full;
  logic        err;
  logic [4:0]  word_count;

  int compared   = 0;
  int mismatched = 0;

  tweak_prog_writer #(.NUMWORDS(8), .ADDRW(4)) dut (
    .CLK        (CLK),
    .NRES       (NRES),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_lsu     (in_lsu),
    .in_alu     (in_alu),
    .in_regs    (in_regs),
    .in_data    (in_data),
    .in_last    (in_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .err        (err),
    .word_count (word_count)
  );

  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic st, input logic vld, input logic [1:0] fmt,
                               input logic [1:0] lsu, input logic [3:0] alu,
                               input logic [11:0] regs, input logic [23:0] data,
                               input logic last);
    start    = st;
    in_valid = vld;
    in_fmt   = fmt;
    in_lsu   = lsu;
    in_alu   = alu;
    in_regs  = regs;
    in_data  = data;
    in_last  = last;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 4'h0, 12'h000, 24'h000000, 1'b0);
  endtask

  task automatic checkAllCleared(input string tag);
    checkOutput({tag, "_we"},    32'(mem_we), 32'd0);
    checkOutput({tag, "_rdy"},   32'(in_ready), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy), 32'd0);
    checkOutput({tag, "_done"},  32'(done), 32'd0);
    checkOutput({tag, "_full"},  32'(full), 32'd0);
    checkOutput({tag, "_err"},   32'(err), 32'd0);
    checkOutput({tag, "_cnt"},   32'(word_count), 32'd0);
    checkOutput({tag, "_addr"},  32'(mem_addr), 32'd0);
    checkOutput({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    NRES = 1'b0;
    idleInputs();

    // Reset state
    repeat (2) @(posedge CLK);
    #2;
    checkAllCleared("reset");
    #1 NRES = 1'b1;

    // Basic pack: fmt 00, lsu 01, alu 0, data FFFFFF, last
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 4'h0, 12'h000, 24'h000000, 1'b0);
    tick();
    checkOutput("first_start_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b01, 4'h0, 12'h000, 24'hFFFFFF, 1'b1);
    checkOutput("basic_ready", 32'(in_ready), 32'd1);
    checkOutput("basic_no_we_fill", 32'(mem_we), 32'd0);
    tick();
    idleInputs();
    checkOutput("basic_we", 32'(mem_we), 32'd1);
    checkOutput("basic_addr", 32'(mem_addr), 32'd0);
    checkOutput("basic_wdata", mem_wdata, 32'h10FFFFFF);
    checkOutput("basic_wr_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("basic_done", 32'(done), 32'd1);
    checkOutput("basic_count", 32'(word_count), 32'd1);
    checkOutput("basic_busy", 32'(busy), 32'd0);
    checkOutput("basic_full", 32'(full), 32'd0);
    checkOutput("basic_we_off", 32'(mem_we), 32'd0);

    // 3-operand: fmt 11, alu 2, regs ABC, data 123
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 4'h0, 12'h000, 24'h000000, 1'b0);
    tick();
    checkOutput("restart_done_clr", 32'(done), 32'd0);
    checkOutput("restart_cnt_clr", 32'(word_count), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b11, 2'b00, 4'h2, 12'hABC, 24'h000123, 1'b1);
    tick();
    idleInputs();
    checkOutput("op3_we", 32'(mem_we), 32'd1);
    checkOutput("op3_addr", 32'(mem_addr), 32'd0);
    checkOutput("op3_wdata", mem_wdata, 32'hC2ABC123);
    tick();
    checkOutput("op3_done", 32'(done), 32'd1);

    // Overflow: fmt 01 with regs 0x1F is dropped, err sticks, next word lands at addr 0
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 4'h0, 12'h000, 24'h000000, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b00, 4'h0, 12'h01F, 24'h000000, 1'b0);
    tick();
    checkOutput("ovf_no_we", 32'(mem_we), 32'd0);
    checkOutput("ovf_err", 32'(err), 32'd1);
    checkOutput("ovf_still_fill", 32'(in_ready), 32'd1);
    checkOutput("ovf_cnt", 32'(word_count), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b10, 4'h3, 12'h005, 24'h0ABCDE, 1'b1);
    tick();
    idleInputs();
    checkOutput("ovf_next_we", 32'(mem_we), 32'd1);
    checkOutput("ovf_next_addr", 32'(mem_addr), 32'd0);
    checkOutput("ovf_next_wdata", mem_wdata, 32'h635ABCDE);
    tick();
    checkOutput("ovf_err_sticky", 32'(err), 32'd1);
    checkOutput("ovf_done", 32'(done), 32'd1);

    // Full: back-to-back words without last
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 4'h0, 12'h000, 24'h000000, 1'b0);
    tick();
    checkOutput("full_err_clr", 32'(err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 4'h0, 12'h000, 24'h000100 + 24'(i), 1'b0);
      tick();
      checkOutput($sformatf("full_we_%0d", i), 32'(mem_we), 32'd1);
      checkOutput($sformatf("full_addr_%0d", i), 32'(mem_addr), 32'(i));
      checkOutput($sformatf("full_wdata_%0d", i), mem_wdata, 32'h00000100 + 32'(i));
      tick();
    end
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 4'h0, 12'h000, 24'h000999, 1'b0);
    checkOutput("full_done", 32'(done), 32'd1);
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_ready", 32'(in_ready), 32'd0);
    checkOutput("full_cnt", 32'(word_count), 32'd8);
    tick();
    tick();
    checkOutput("full_9th_no_we", 32'(mem_we), 32'd0);
    checkOutput("full_9th_cnt", 32'(word_count), 32'd8);
    idleInputs();

    // Restart in FILL beats a same-cycle handshake
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 4'h0, 12'h000, 24'h000000, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 4'h1, 12'h000, 24'h000011, 1'b0);
    tick();
    idleInputs();
    tick();
    checkOutput("rs_pre_cnt", 32'(word_count), 32'd1);
    checkOutput("rs_pre_addr", 32'(mem_addr), 32'd1);
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 4'h1, 12'h000, 24'h000022, 1'b0);
    checkOutput("rs_ready_low", 32'(in_ready), 32'd0);
    tick();
    checkOutput("rs_no_we", 32'(mem_we), 32'd0);
    checkOutput("rs_cnt", 32'(word_count), 32'd0);
    checkOutput("rs_addr", 32'(mem_addr), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 4'h1, 12'h000, 24'h000033, 1'b0);
    tick();
    idleInputs();
    checkOutput("rs_we", 32'(mem_we), 32'd1);
    checkOutput("rs_wr_addr", 32'(mem_addr), 32'd0);
    checkOutput("rs_wdata", mem_wdata, 32'h01000033);

    // Reset pulsed mid-WRITE
    NRES = 1'b0;
    #1;
    checkAllCleared("midrst");
    #1 NRES = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 4'h0, 12'h000, 24'h000000, 1'b0);
    tick();
    idleInputs();
    checkOutput("postrst_busy", 32'(busy), 32'd1);
    checkOutput("postrst_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tweak_prog_writer.md
TWEAK_PROG_WRITER -- requirements
Module: tweak_prog_writer

Interface
REQ-001 Parameter NUMWORDS, default 8: instruction-memory depth in words.
REQ-002 Parameter ADDRW, default 4: memory address width.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 NRES  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begins a program load at address 0.
REQ-006 in_valid  input  1  instruction fields are valid.
REQ-007 in_ready  output  1  writer accepts fields this cycle.
REQ-008 in_fmt, in_lsu, in_alu  input  2/2/4  format code, LSU opcode, ALU opcode.
REQ-009 in_regs, in_data  input  12/24  register field (right-justified), immediate data (right-justified).
REQ-010 in_last  input  1  marks the final instruction of the program.
REQ-011 mem_we, mem_addr, mem_wdata  output  1/ADDRW/32  instruction-memory write port.
REQ-012 busy, done, full, err  output  1 each  status flags.
REQ-013 word_count  output  ADDRW+1  number of words written since the last start.

Function
REQ-014 Encoding SHALL be {fmt[1:0], lsu[1:0], alu[3:0], payload[23:0]}.
REQ-015 Payload by format:
  - 00: data[23:0]
  - 01: {regs[3:0], data[19:0]}
  - 10: {regs[7:0], data[15:0]}
  - 11: {regs[11:0], data[11:0]}
REQ-016 Field overflow SHALL be nonzero in_regs bits above the format's register width, or nonzero in_data bits above its data width; format 00 SHALL ignore in_regs.
REQ-017 FSM states SHALL be IDLE, FILL, WRITE, DONE.
REQ-018 IDLE:
  - in_ready=0.
  - start -> FILL with address=0, word_count=0, err=0, full=0, done=0.
REQ-019 FILL:
  - in_ready=1 unless start=1.
  - A handshake (in_valid & in_ready) without overflow SHALL register the encoded word and in_last, then go to WRITE.
REQ-020 A handshake with overflow SHALL drop the word, set err (sticky) and remain in FILL.
REQ-021 WRITE:
  - mem_we=1 for exactly one cycle with the current address and word; then address and word_count increment.
  - Latency is handshake at cycle N -> mem_we at N+1.
  - in_ready=0, so throughput is one word per 2 cycles.
REQ-022 After WRITE: if the registered in_last=1, or word_count reaches NUMWORDS, go to DONE; otherwise return to FILL.
REQ-023 full SHALL be set on entry to DONE when word_count==NUMWORDS, including when in_last also coincides.
REQ-024 DONE:
  - done=1 (level), in_ready=0.
  - Hold until start, which acts as in REQ-018.
REQ-025 start in FILL or WRITE SHALL restart the load (address 0, flags cleared) and take priority over a same-cycle handshake. In WRITE, the pending write still completes that cycle.
REQ-026 busy SHALL be 1 in FILL and WRITE, 0 otherwise.
REQ-027 mem_addr SHALL never exceed NUMWORDS-1; no write SHALL occur outside WRITE.

Reset
REQ-028 NRES low SHALL asynchronously force:
  - state IDLE;
  - address 0, word_count 0;
  - mem_we, in_ready, busy, done, full and err all 0;
  - mem_wdata 0.
REQ-029 Reset mid-write SHALL abort the write; mem_we drops immediately.
REQ-030 The first start SHALL be honoured on the first rising edge after NRES deasserts.

Structure
REQ-031 Format codes, field widths, state encodings and the ALU/LSU opcode constants SHALL live in a shared tweak package, also used by the decoder.
REQ-032 Packing and overflow checking SHALL be one combinational sub-module, tweak_encoder; tweak_prog_writer holds only the FSM, counters and write port.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
  - Basic pack: start, then format 00, lsu 01, alu 0, data FFFFFF with in_last -> one write, addr 0, wdata 0x10FFFFFF; then done=1, word_count=1.
  - 3-operand: format 11, alu 2, regs ABC, data 123 -> wdata 0xC2ABC123, written one cycle after handshake.
  - Overflow: format 01, regs 0x1F -> no mem_we, err=1, still FILL; the next valid word is written at addr 0.
  - Full: 9 back-to-back words with no in_last -> writes at addr 0..7; done=1, full=1, in_ready=0; 9th word never accepted.
  - Restart/reset: start asserted in the same cycle as in_valid during FILL -> no handshake, address 0. NRES pulsed during WRITE -> mem_we=0 immediately, all flags 0.
